shift_seq_unit: RTL



---
 rtl/shift_seq_pkg.sv | 22 ++
 rtl/shift_seq_unit_shift_step.sv | 52 +++++
 rtl/shift_seq_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift responder.
// Optional rotate support is selected by defining SHIFT_SEQ_ROTATE_EN.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_REM_W = $clog2(DEFAULT_WIDTH + 1);

  // The remaining-amount counter must hold every value from 0 up to WIDTH.
  function automatic int unsigned rem_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_seq_unit_shift_step.sv
// Combinational shift of 0..STEP bit positions with a selectable fill bit.
// With SHIFT_SEQ_ROTATE_EN defined, a rot input wraps vacated bits instead.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic             fill,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] data_o
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fill_mask;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic [31:0]      back_amt;
  logic [WIDTH-1:0] wrapped;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    shifted   = '0;
    fill_mask = '0;
    if (dir == DIR_LEFT) begin
      shifted   = data_i << amt;
      fill_mask = ~(ONES << amt);
    end else begin
      shifted   = data_i >> amt;
      fill_mask = ~(ONES >> amt);
    end
    data_o = shifted | (fill ? fill_mask : '0);
`ifdef SHIFT_SEQ_ROTATE_EN
    // A zero-bit step shifts by WIDTH here, which yields zero wrap bits.
    back_amt = 32'(WIDTH) - 32'(amt);
    wrapped  = (dir == DIR_LEFT) ? (data_i >> back_amt) : (data_i << back_amt);
    if (rot) begin
      data_o = shifted | wrapped;
    end
`endif
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: accepts a request, shifts up to STEP bits per cycle,
// then holds the result for a valid/ready handoff. Rotate: SHIFT_SEQ_ROTATE_EN.
module shift_seq_unit
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [31:0]      operand2,
  input  logic             dir,
  input  logic             arith,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int unsigned REM_W = rem_width(WIDTH);
  localparam int unsigned AMT_W = $clog2(STEP + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [REM_W-1:0] rem_q,   rem_d;
  logic             dir_q,   dir_d;
  logic             arith_q, arith_d;
  logic             sign_q,  sign_d;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             rot_q,   rot_d;
`endif

  logic [REM_W-1:0] clamp_amt;
  logic [AMT_W-1:0] step_amt;
  logic             fill_bit;
  logic [WIDTH-1:0] step_out;

  assign clamp_amt = (operand2 >= 32'(WIDTH)) ? REM_W'(WIDTH) : REM_W'(operand2);
  assign step_amt  = (rem_q > REM_W'(STEP)) ? AMT_W'(STEP) : AMT_W'(rem_q);
`ifdef SHIFT_SEQ_ROTATE_EN
  assign fill_bit  = (dir_q == DIR_RIGHT) && arith_q && sign_q && !rot_q;
`else
  assign fill_bit  = (dir_q == DIR_RIGHT) && arith_q && sign_q;
`endif

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .data_i (data_q),
    .amt    (step_amt),
    .dir    (dir_q),
    .fill   (fill_bit),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rot    (rot_q),
`endif
    .data_o (step_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    sign_d  = sign_q;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = operand1;
          dir_d   = dir;
          arith_d = arith;
          sign_d  = operand1[WIDTH-1];
          rem_d   = clamp_amt;
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_d   = rot;
          if (rot) begin
            rem_d = REM_W'(operand2 % 32'(WIDTH));
          end
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The last step may be a zero-bit step when the amount was zero.
        data_d = step_out;
        rem_d  = rem_q - REM_W'(step_amt);
        if (rem_q <= REM_W'(STEP)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      dir_q   <= DIR_LEFT;
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
      sign_q  <= sign_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = data_q;

endmodule
